// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit pipeline: opcodes, instruction fields, control bundle.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int NREG   = 4;
  localparam int REG_W  = 2;
  localparam int OP_W   = 3;
  localparam int INST_W = 8;

  // Instruction field positions
  localparam int OP_MSB   = 7;
  localparam int OP_LSB   = 5;
  localparam int RS_MSB   = 4;
  localparam int RS_LSB   = 3;
  localparam int RT_MSB   = 2;
  localparam int RT_LSB   = 1;
  localparam int IMM5_MSB = 4;
  localparam int IMM3_MSB = 2;
  localparam int JHI_LSB  = 5;  // pc bits kept in a jump target

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_ADDI = 3'b010,
    OP_LW   = 3'b011,
    OP_SW   = 3'b100,
    OP_BEQ  = 3'b101,
    OP_J    = 3'b110,
    OP_HALT = 3'b111
  } opcode_e;

  typedef struct packed {
    logic regwrite;
    logic memread;
    logic memwrite;
    logic branch;
    logic jump;
    logic halt;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  function automatic ctrl_t decode_ctrl(input opcode_e op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_ADD, OP_SUB, OP_ADDI: c.regwrite = 1'b1;
      OP_LW: begin
        c.regwrite = 1'b1;
        c.memread  = 1'b1;
      end
      OP_SW:   c.memwrite = 1'b1;
      OP_BEQ:  c.branch   = 1'b1;
      OP_J:    c.jump     = 1'b1;
      OP_HALT: c.halt     = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // Ops whose rt field names a source register
  function automatic logic uses_rt(input opcode_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

  // Ops that carry a 3-bit signed immediate in [2:0]
  function automatic logic uses_imm3(input opcode_e op);
    return (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/reg_file.sv
// 4x8 register file, r0 hard-wired to zero, two read ports with write-through bypass.
// Latency: reads combinational; write lands on the clock edge.
// Backpressure: none; a write is accepted every cycle i_we is high.
module reg_file
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [REG_W-1:0]  i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_dat,
  input  logic [REG_W-1:0]  i_rd0_addr,
  output logic [DATA_W-1:0] o_rd0_dat,
  input  logic [REG_W-1:0]  i_rd1_addr,
  output logic [DATA_W-1:0] o_rd1_dat
);

  logic [DATA_W-1:0] r_mem [NREG];
  logic              w_byp0;
  logic              w_byp1;

  // Storage: clear on reset, otherwise write any register except r0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (i_we && (i_wr_addr != '0)) begin
      r_mem[i_wr_addr] <= i_wr_dat;
    end
  end

  // A write in the same cycle is visible to the reader; r0 always reads zero
  assign w_byp0    = i_we && (i_wr_addr == i_rd0_addr);
  assign w_byp1    = i_we && (i_wr_addr == i_rd1_addr);
  assign o_rd0_dat = (i_rd0_addr == '0) ? '0 : (w_byp0 ? i_wr_dat : r_mem[i_rd0_addr]);
  assign o_rd1_dat = (i_rd1_addr == '0) ? '0 : (w_byp1 ? i_wr_dat : r_mem[i_rd1_addr]);

endmodule

// File: rtl/id_stage.sv
// Decode stage: IF/ID latch, field decode, register read, registered ID/EX bundle.
// Latency: instruction sampled at edge N is on ex_* after edge N+1.
// Backpressure: stall_if holds fetch on load-use hazard or after HALT; flush overrides stall.
module id_stage
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [INST_W-1:0] inst_in,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall_if,
  output logic              ex_valid,
  output logic [OP_W-1:0]   ex_op,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [ADDR_W-1:0] ex_pc,
  output logic [ADDR_W-1:0] ex_jtarget,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_branch,
  output logic              ex_jump,
  output logic              ex_halt
);

  // IF/ID register
  logic              r_ifid_vld;
  logic [INST_W-1:0] r_ifid_inst;
  logic [ADDR_W-1:0] r_ifid_pc;

  // ID/EX register
  logic              r_ex_vld;
  logic [OP_W-1:0]   r_ex_op;
  logic [REG_W-1:0]  r_ex_rs;
  logic [REG_W-1:0]  r_ex_rt;
  logic [DATA_W-1:0] r_ex_a;
  logic [DATA_W-1:0] r_ex_b;
  logic [DATA_W-1:0] r_ex_imm;
  logic [ADDR_W-1:0] r_ex_pc;
  logic [ADDR_W-1:0] r_ex_jt;
  ctrl_t             r_ex_ctrl;

  logic              r_halted;

  // Decode of the instruction sitting in IF/ID
  opcode_e           w_id_op;
  logic [REG_W-1:0]  w_id_rs;
  logic [REG_W-1:0]  w_id_rt;
  logic [DATA_W-1:0] w_id_imm;
  logic [ADDR_W-1:0] w_id_jt;
  ctrl_t             w_id_ctrl;
  logic [DATA_W-1:0] w_rs_dat;
  logic [DATA_W-1:0] w_rt_dat;
  logic              w_hazard;
  logic              w_hold;
  logic              w_issue;

  assign w_id_op   = opcode_e'(r_ifid_inst[OP_MSB:OP_LSB]);
  assign w_id_rs   = r_ifid_inst[RS_MSB:RS_LSB];
  assign w_id_rt   = r_ifid_inst[RT_MSB:RT_LSB];
  assign w_id_ctrl = decode_ctrl(w_id_op);
  assign w_id_imm  = uses_imm3(w_id_op)
                   ? {{(DATA_W-IMM3_MSB-1){r_ifid_inst[IMM3_MSB]}}, r_ifid_inst[IMM3_MSB:0]}
                   : '0;
  assign w_id_jt   = {r_ifid_pc[ADDR_W-1:JHI_LSB], r_ifid_inst[IMM5_MSB:0]};

  reg_file u_reg_file (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_we       (wb_we),
    .i_wr_addr  (wb_rd),
    .i_wr_dat   (wb_data),
    .i_rd0_addr (w_id_rs),
    .o_rd0_dat  (w_rs_dat),
    .i_rd1_addr (w_id_rt),
    .o_rd1_dat  (w_rt_dat)
  );

  // A load in EX cannot forward in time to a dependent instruction in decode.
  // r0 is excluded because it never carries loaded data.
  assign w_hazard = r_ex_vld && r_ex_ctrl.memread && (r_ex_rs != '0) &&
                    ((r_ex_rs == w_id_rs) || ((r_ex_rs == w_id_rt) && uses_rt(w_id_op)));
  assign w_hold   = w_hazard || r_halted;
  assign stall_if = w_hold && !flush;
  assign w_issue  = r_ifid_vld && !flush && !w_hold;

  // IF/ID: follow fetch unless stalled; a flush kills whatever is being latched
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ifid_vld  <= 1'b0;
      r_ifid_inst <= '0;
      r_ifid_pc   <= '0;
    end else if (!stall_if) begin
      r_ifid_vld  <= !flush;
      r_ifid_inst <= inst_in;
      r_ifid_pc   <= pc_in;
    end
  end

  // ID/EX: issue the decoded instruction or insert an all-zero bubble
  always_ff @(posedge clk) begin
    if (!rst_n || !w_issue) begin
      r_ex_vld  <= 1'b0;
      r_ex_op   <= '0;
      r_ex_rs   <= '0;
      r_ex_rt   <= '0;
      r_ex_a    <= '0;
      r_ex_b    <= '0;
      r_ex_imm  <= '0;
      r_ex_pc   <= '0;
      r_ex_jt   <= '0;
      r_ex_ctrl <= '0;
    end else begin
      r_ex_vld  <= 1'b1;
      r_ex_op   <= w_id_op;
      r_ex_rs   <= w_id_rs;
      r_ex_rt   <= w_id_rt;
      r_ex_a    <= w_rs_dat;
      r_ex_b    <= w_rt_dat;
      r_ex_imm  <= w_id_imm;
      r_ex_pc   <= r_ifid_pc;
      r_ex_jt   <= w_id_jt;
      r_ex_ctrl <= w_id_ctrl;
    end
  end

  // Halted flag: set when HALT issues into EX, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_halted <= 1'b0;
    end else if (w_issue && w_id_ctrl.halt) begin
      r_halted <= 1'b1;
    end
  end

  assign ex_valid    = r_ex_vld;
  assign ex_op       = r_ex_op;
  assign ex_rs       = r_ex_rs;
  assign ex_rt       = r_ex_rt;
  assign ex_a        = r_ex_a;
  assign ex_b        = r_ex_b;
  assign ex_imm      = r_ex_imm;
  assign ex_pc       = r_ex_pc;
  assign ex_jtarget  = r_ex_jt;
  assign ex_regwrite = r_ex_vld && r_ex_ctrl.regwrite;
  assign ex_memread  = r_ex_vld && r_ex_ctrl.memread;
  assign ex_memwrite = r_ex_vld && r_ex_ctrl.memwrite;
  assign ex_branch   = r_ex_vld && r_ex_ctrl.branch;
  assign ex_jump     = r_ex_vld && r_ex_ctrl.jump;
  assign ex_halt     = r_ex_vld && r_ex_ctrl.halt;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios then random traffic against a behavioural model.
// Latency: model predicts ex_* one edge after the instruction leaves IF/ID.
// Backpressure: bench re-presents the held fetch slot whenever stall_if is predicted.
module tb_id_stage;

  logic       clk = 1'b0;
  logic       rst_n, flush, wb_we;
  logic [7:0] inst_in, pc_in, wb_data;
  logic [1:0] wb_rd;
  logic       stall_if, ex_valid;
  logic [2:0] ex_op;
  logic [1:0] ex_rs, ex_rt;
  logic [7:0] ex_a, ex_b, ex_imm, ex_pc, ex_jtarget;
  logic       ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_jump, ex_halt;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst_n(rst_n), .inst_in(inst_in), .pc_in(pc_in), .flush(flush),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .stall_if(stall_if),
    .ex_valid(ex_valid), .ex_op(ex_op), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_pc(ex_pc), .ex_jtarget(ex_jtarget),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_halt(ex_halt)
  );

  typedef struct {
    logic       vld;
    logic [2:0] op;
    logic [1:0] rs, rt;
    logic [7:0] a, b, imm, pc, jt;
    logic       rw, mr, mw, br, jp, ht;
  } exp_t;

  int   n_cmp = 0;
  int   n_err = 0;
  logic last_stall;

  // Behavioural model state
  int   m_rf [4];
  logic m_ifid_vld;
  logic [7:0] m_inst, m_pc;
  exp_t m_ex;
  logic m_halted;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, want 0x%h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t zero_exp();
    exp_t e;
    e = '{vld: 0, op: 0, rs: 0, rt: 0, a: 0, b: 0, imm: 0, pc: 0, jt: 0,
          rw: 0, mr: 0, mw: 0, br: 0, jp: 0, ht: 0};
    return e;
  endfunction

  function automatic logic [7:0] rf_read(input int r, input logic we, input int rd,
                                         input logic [7:0] dat);
    if (r == 0) return 8'h00;
    if (we && rd == r) return dat;
    return 8'(m_rf[r]);
  endfunction

  function automatic exp_t model_decode(input logic [7:0] ins, input logic [7:0] pc,
                                        input logic we, input logic [1:0] rd,
                                        input logic [7:0] dat);
    exp_t e;
    int   op, v;
    e     = zero_exp();
    op    = int'(ins) / 32;
    e.vld = 1'b1;
    e.op  = 3'(op);
    e.rs  = 2'((int'(ins) / 8) % 4);
    e.rt  = 2'((int'(ins) / 2) % 4);
    e.a   = rf_read(int'(e.rs), we, int'(rd), dat);
    e.b   = rf_read(int'(e.rt), we, int'(rd), dat);
    e.pc  = pc;
    e.jt  = 8'((int'(pc) / 32) * 32 + int'(ins) % 32);
    if (op >= 2 && op <= 5) begin
      v = int'(ins) % 8;
      if (v > 3) v = v - 8;
      e.imm = 8'(v);
    end
    e.rw = (op <= 3);
    e.mr = (op == 3);
    e.mw = (op == 4);
    e.br = (op == 5);
    e.jp = (op == 6);
    e.ht = (op == 7);
    return e;
  endfunction

  task automatic check_outputs();
    chk("ex_valid",    8'(ex_valid),    8'(m_ex.vld));
    chk("ex_op",       8'(ex_op),       8'(m_ex.op));
    chk("ex_rs",       8'(ex_rs),       8'(m_ex.rs));
    chk("ex_rt",       8'(ex_rt),       8'(m_ex.rt));
    chk("ex_a",        ex_a,            m_ex.a);
    chk("ex_b",        ex_b,            m_ex.b);
    chk("ex_imm",      ex_imm,          m_ex.imm);
    chk("ex_pc",       ex_pc,           m_ex.pc);
    chk("ex_jtarget",  ex_jtarget,      m_ex.jt);
    chk("ex_regwrite", 8'(ex_regwrite), 8'(m_ex.rw));
    chk("ex_memread",  8'(ex_memread),  8'(m_ex.mr));
    chk("ex_memwrite", 8'(ex_memwrite), 8'(m_ex.mw));
    chk("ex_branch",   8'(ex_branch),   8'(m_ex.br));
    chk("ex_jump",     8'(ex_jump),     8'(m_ex.jp));
    chk("ex_halt",     8'(ex_halt),     8'(m_ex.ht));
  endtask

  // One clock: drive inputs, check the predicted stall, advance the model, check outputs
  task automatic step(input logic [7:0] i_inst, input logic [7:0] i_pc, input logic i_fl,
                      input logic i_we, input logic [1:0] i_rd, input logic [7:0] i_dat,
                      input logic i_rstn);
    int   op, rs, rt, ers;
    logic hz, st;
    exp_t nx;
    @(negedge clk);
    inst_in = i_inst; pc_in = i_pc; flush = i_fl;
    wb_we = i_we; wb_rd = i_rd; wb_data = i_dat; rst_n = i_rstn;
    op  = int'(m_inst) / 32;
    rs  = (int'(m_inst) / 8) % 4;
    rt  = (int'(m_inst) / 2) % 4;
    ers = int'(m_ex.rs);
    hz  = m_ex.vld && m_ex.mr && ers != 0 &&
          (ers == rs || (ers == rt && (op == 0 || op == 1 || op == 4 || op == 5)));
    st  = !i_fl && (hz || m_halted);
    #1;
    chk("stall_if", 8'(stall_if), 8'(st));
    last_stall = stall_if;
    if (!i_rstn) begin
      m_ifid_vld = 1'b0; m_inst = 8'h00; m_pc = 8'h00;
      m_ex = zero_exp(); m_halted = 1'b0;
      for (int i = 0; i < 4; i++) m_rf[i] = 0;
    end else begin
      nx = zero_exp();
      if (m_ifid_vld && !i_fl && !st) nx = model_decode(m_inst, m_pc, i_we, i_rd, i_dat);
      if (nx.vld && nx.ht) m_halted = 1'b1;
      m_ex = nx;
      if (!st) begin
        m_inst = i_inst; m_pc = i_pc; m_ifid_vld = !i_fl;
      end
      if (i_we && i_rd != 2'd0) m_rf[i_rd] = int'(i_dat);
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  localparam logic [7:0] NOP = 8'h00;  // ADD r0,r0

  initial begin
    logic [7:0] ins, pc;
    logic       fl, we, rstn;
    int         halt_cnt;
    rst_n = 1'b0; flush = 1'b0; wb_we = 1'b0; wb_rd = 2'd0; wb_data = 8'h00;
    inst_in = 8'h00; pc_in = 8'h00;
    m_ifid_vld = 1'b0; m_inst = 8'h00; m_pc = 8'h00; m_ex = zero_exp(); m_halted = 1'b0;
    for (int i = 0; i < 4; i++) m_rf[i] = 0;

    // Reset state
    step(NOP, 8'h00, 0, 0, 2'd0, 8'h00, 0);
    step(NOP, 8'h00, 0, 0, 2'd0, 8'h00, 0);
    chk("rst_valid", 8'(ex_valid), 8'h00);
    chk("rst_stall", 8'(stall_if), 8'h00);

    // ADDI r1,+3 at pc 0x02
    step(8'b010_01_011, 8'h02, 0, 0, 2'd0, 8'h00, 1);
    step(NOP, 8'h03, 0, 0, 2'd0, 8'h00, 1);
    chk("addi_valid", 8'(ex_valid), 8'h01);
    chk("addi_op",    8'(ex_op),    8'h02);
    chk("addi_rs",    8'(ex_rs),    8'h01);
    chk("addi_imm",   ex_imm,       8'h03);
    chk("addi_rw",    8'(ex_regwrite), 8'h01);
    chk("addi_pc",    ex_pc,        8'h02);

    // Write-through bypass and r0 immunity
    step(8'b000_01_10_0, 8'h04, 0, 0, 2'd0, 8'h00, 1);
    step(NOP, 8'h05, 0, 1, 2'd2, 8'hA5, 1);
    chk("bypass_b", ex_b, 8'hA5);
    step(8'b000_00_00_0, 8'h06, 0, 0, 2'd0, 8'h00, 1);
    step(NOP, 8'h07, 0, 1, 2'd0, 8'hFF, 1);
    chk("r0_a", ex_a, 8'h00);
    chk("r0_b", ex_b, 8'h00);

    // Load-use: LW r1 then ADD r2,r1
    step(8'b011_01_000, 8'h08, 0, 0, 2'd0, 8'h00, 1);
    step(8'b000_10_01_0, 8'h09, 0, 0, 2'd0, 8'h00, 1);
    step(NOP, 8'h0A, 0, 0, 2'd0, 8'h00, 1);
    chk("lu_stall", 8'(last_stall), 8'h01);
    chk("lu_bubble", 8'(ex_valid), 8'h00);
    step(NOP, 8'h0A, 0, 0, 2'd0, 8'h00, 1);
    chk("lu_stall_once", 8'(last_stall), 8'h00);
    chk("lu_add_valid", 8'(ex_valid), 8'h01);
    chk("lu_add_rt", 8'(ex_rt), 8'h01);

    // Flush with a stall pending
    step(8'b011_01_000, 8'h0B, 0, 0, 2'd0, 8'h00, 1);
    step(8'b000_10_01_0, 8'h0C, 0, 0, 2'd0, 8'h00, 1);
    step(NOP, 8'h0D, 1, 0, 2'd0, 8'h00, 1);
    chk("fl_stall", 8'(last_stall), 8'h00);
    chk("fl_valid0", 8'(ex_valid), 8'h00);
    chk("fl_rw0", 8'(ex_regwrite), 8'h00);
    step(NOP, 8'h0E, 0, 0, 2'd0, 8'h00, 1);
    chk("fl_valid1", 8'(ex_valid), 8'h00);
    chk("fl_mr1", 8'(ex_memread), 8'h00);

    // Jump target and negative immediate
    step(8'b110_11111, 8'h45, 0, 0, 2'd0, 8'h00, 1);
    step(NOP, 8'h46, 0, 0, 2'd0, 8'h00, 1);
    chk("j_jump", 8'(ex_jump), 8'h01);
    chk("j_target", ex_jtarget, 8'h5F);
    step(8'b010_01_111, 8'h47, 0, 0, 2'd0, 8'h00, 1);
    step(NOP, 8'h48, 0, 0, 2'd0, 8'h00, 1);
    chk("addi_neg_imm", ex_imm, 8'hFF);

    // HALT then reset
    step(8'hE0, 8'h49, 0, 0, 2'd0, 8'h00, 1);
    step(NOP, 8'h4A, 0, 0, 2'd0, 8'h00, 1);
    chk("halt_issue", 8'(ex_halt), 8'h01);
    for (int i = 0; i < 10; i++) begin
      step(NOP, 8'h4B, 0, 0, 2'd0, 8'h00, 1);
      chk("halt_stall", 8'(last_stall), 8'h01);
      chk("halt_bubble", 8'(ex_valid), 8'h00);
    end
    step(NOP, 8'h00, 0, 0, 2'd0, 8'h00, 0);
    chk("halt_rst_stall", 8'(stall_if), 8'h00);
    step(8'b010_01_011, 8'h02, 0, 0, 2'd0, 8'h00, 1);
    step(NOP, 8'h03, 0, 0, 2'd0, 8'h00, 1);
    chk("resume_valid", 8'(ex_valid), 8'h01);
    chk("resume_op", 8'(ex_op), 8'h02);

    // Random traffic
    pc = 8'h10;
    halt_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      ins = 8'($urandom);
      if (ins[7:5] == 3'b111 && $urandom_range(0, 9) != 0) ins[7:5] = 3'($urandom_range(0, 6));
      fl   = ($urandom_range(0, 15) == 0);
      we   = $urandom_range(0, 1) == 1;
      rstn = !(halt_cnt > 12 || $urandom_range(0, 299) == 0);
      if (!last_stall) pc = pc + 8'd1;
      step(ins, pc, fl, we, 2'($urandom_range(0, 3)), 8'($urandom), rstn);
      halt_cnt = m_halted ? halt_cnt + 1 : 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
